roi_axis_framer: RTL and testbench

Upstream stage of the ROI crop block: accepts a raw pixel AXI Stream from the capture side and re-emits it with clean, counter-generated framing. Emits start-of-frame (tuser) on pixel (0,0) and end-of-line (tlast) on every pixel x = WIDTH-1. Flags and recovers from malformed source framing, so the ROI block can trust tlast and pixel positions. A 2-entry registered skid buffer decouples backpressure in both directions.

---
 rtl/roi_axis_framer_pkg.sv | 16 +
 rtl/roi_axis_framer_if.sv | 15 +
 rtl/roi_axis_framer_skid2.sv | 90 +++++++++
 rtl/roi_axis_framer.sv | 136 +++++++++++++
 tb/tb_roi_axis_framer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/roi_axis_framer_pkg.sv
// Shared definitions for the ROI crop path: default geometry and the pixel beat
// layout that both the framer and the downstream ROI block carry.
package roi_pkg;

    localparam int DEF_PIXEL_SIZE = 8;
    localparam int DEF_WIDTH      = 1920;
    localparam int DEF_HEIGHT     = 1080;
    localparam int DEF_XW         = 11;

    typedef struct packed {
        logic [DEF_PIXEL_SIZE-1:0] tdata;
        logic                      tuser;
        logic                      tlast;
    } pix_beat_t;

endpackage

// File: rtl/roi_axis_framer_if.sv
// Pixel AXI Stream bundle; master drives payload and valid, slave drives ready.
interface roi_axis_framer_if #(
    parameter int PIXEL_SIZE = 8
) ();

    logic [PIXEL_SIZE-1:0] tdata;
    logic                  tvalid;
    logic                  tuser;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/roi_axis_framer_skid2.sv
// Generic 2-entry skid buffer: head register drives the output, a second entry
// absorbs one beat of backpressure so the upstream ready can be registered.
module axis_skid2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         head_valid_q, head_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q, ready_d;
    logic         in_xfer;
    logic         out_xfer;

    // Occupancy transitions; ready is kept as its own flop so it is 0 during reset.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        in_xfer      = i_valid & ready_q;
        out_xfer     = head_valid_q & i_ready;
        case ({head_valid_q, skid_valid_q})
            2'b00: begin
                if (in_xfer) begin
                    head_d       = i_data;
                    head_valid_d = 1'b1;
                end else begin
                    head_valid_d = 1'b0;
                end
            end
            2'b10: begin
                if (in_xfer && out_xfer) begin
                    head_d = i_data;
                end else if (in_xfer) begin
                    skid_d       = i_data;
                    skid_valid_d = 1'b1;
                end else if (out_xfer) begin
                    head_valid_d = 1'b0;
                end else begin
                    head_valid_d = 1'b1;
                end
            end
            2'b11: begin
                if (out_xfer) begin
                    head_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else begin
                    skid_valid_d = 1'b1;
                end
            end
            default: begin
                head_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
        ready_d = ~skid_valid_d;
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= {W{1'b0}};
            skid_q       <= {W{1'b0}};
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_data  = head_q;
    assign o_valid = head_valid_q;

endmodule

// File: rtl/roi_axis_framer.sv
// Re-frames a raw pixel stream from x/y counters: SOF on (0,0), EOL on x=WIDTH-1,
// with sticky flags for malformed source framing and a completed-frame counter.
module roi_axis_framer
    import roi_pkg::*;
#(
    parameter int PIXEL_SIZE = DEF_PIXEL_SIZE,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int XW         = DEF_XW
) (
    input  logic                    clk,
    input  logic                    rst,
    roi_axis_framer_if.slave        s_axis,
    roi_axis_framer_if.master       m_axis,
    input  logic                    i_err_clr,
    output logic                    o_err_early_eol,
    output logic                    o_err_late_eol,
    output logic                    o_err_sof,
    output logic [15:0]             o_frame_cnt
);

    localparam int             PW     = PIXEL_SIZE + 2;
    localparam logic [XW-1:0]  X_LAST = XW'(WIDTH - 1);
    localparam logic [XW-1:0]  Y_LAST = XW'(HEIGHT - 1);
    localparam logic [XW-1:0]  X_ONE  = {{(XW-1){1'b0}}, 1'b1};

    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] y_q, y_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          err_early_eol_q, err_early_eol_d;
    logic          err_late_eol_q, err_late_eol_d;
    logic          err_sof_q, err_sof_d;

    logic          in_xfer;
    logic          at_origin;
    logic          at_eol;
    logic          out_tuser;
    logic          out_tlast;
    logic          set_sof;
    logic          set_early;
    logic          set_late;
    logic          wrap_line;
    logic [PW-1:0] head_beat;

    // Framing flags and counter update; a stray SOF restarts the frame at (0,0)
    // and takes precedence over any EOL disagreement on the same beat.
    always_comb begin
        in_xfer     = s_axis.tvalid & s_axis.tready;
        at_origin   = (x_q == {XW{1'b0}}) && (y_q == {XW{1'b0}});
        at_eol      = (x_q == X_LAST);
        out_tuser   = at_origin;
        out_tlast   = at_eol;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        set_sof     = 1'b0;
        set_early   = 1'b0;
        set_late    = 1'b0;
        wrap_line   = 1'b0;
        if (in_xfer) begin
            if (s_axis.tuser && !at_origin) begin
                set_sof   = 1'b1;
                out_tuser = 1'b1;
                out_tlast = 1'b0;
                x_d       = X_ONE;
                y_d       = {XW{1'b0}};
            end else if (s_axis.tlast && !at_eol) begin
                set_early = 1'b1;
                out_tlast = 1'b1;
                wrap_line = 1'b1;
            end else if (at_eol) begin
                set_late  = ~s_axis.tlast;
                wrap_line = 1'b1;
            end else begin
                x_d = x_q + X_ONE;
            end
        end else begin
            wrap_line = 1'b0;
        end
        if (wrap_line) begin
            x_d = {XW{1'b0}};
            if (y_q == Y_LAST) begin
                y_d         = {XW{1'b0}};
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                y_d = y_q + X_ONE;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        err_sof_d       = set_sof   | (err_sof_q       & ~i_err_clr);
        err_early_eol_d = set_early | (err_early_eol_q & ~i_err_clr);
        err_late_eol_d  = set_late  | (err_late_eol_q  & ~i_err_clr);
    end

    // Counter and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q             <= {XW{1'b0}};
            y_q             <= {XW{1'b0}};
            frame_cnt_q     <= 16'd0;
            err_sof_q       <= 1'b0;
            err_early_eol_q <= 1'b0;
            err_late_eol_q  <= 1'b0;
        end else begin
            x_q             <= x_d;
            y_q             <= y_d;
            frame_cnt_q     <= frame_cnt_d;
            err_sof_q       <= err_sof_d;
            err_early_eol_q <= err_early_eol_d;
            err_late_eol_q  <= err_late_eol_d;
        end
    end

    axis_skid2 #(
        .W (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({s_axis.tdata, out_tuser, out_tlast}),
        .i_valid (s_axis.tvalid),
        .o_ready (s_axis.tready),
        .o_data  (head_beat),
        .o_valid (m_axis.tvalid),
        .i_ready (m_axis.tready)
    );

    assign m_axis.tdata    = head_beat[PW-1:2];
    assign m_axis.tuser    = head_beat[1];
    assign m_axis.tlast    = head_beat[0];
    assign o_err_early_eol = err_early_eol_q;
    assign o_err_late_eol  = err_late_eol_q;
    assign o_err_sof       = err_sof_q;
    assign o_frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_roi_axis_framer.sv
// Scoreboard bench for roi_axis_framer on an 8x4 frame: stimulus pushes expected
// beats, a negedge monitor pops and compares each output transfer.
module tb_roi_axis_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clr = 1'b0;
    logic        err_early, err_late, err_sof;
    logic [15:0] frame_cnt;

    logic        rand_mode = 1'b0;
    logic        ready_fixed = 1'b1;
    logic        occ_en = 1'b0;
    logic [7:0]  dval = 8'h10;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q[$];

    roi_axis_framer_if #(.PIXEL_SIZE(8)) s_if ();
    roi_axis_framer_if #(.PIXEL_SIZE(8)) m_if ();

    roi_axis_framer #(
        .PIXEL_SIZE (8),
        .WIDTH      (8),
        .HEIGHT     (4),
        .XW         (11)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis          (s_if.slave),
        .m_axis          (m_if.master),
        .i_err_clr       (err_clr),
        .o_err_early_eol (err_early),
        .o_err_late_eol  (err_late),
        .o_err_sof       (err_sof),
        .o_frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%0h req=%0h", name, act, req);
        end
    endtask

    // Output ready: fixed or random, updated just after the rising edge.
    always @(posedge clk) begin
        #1;
        m_if.tready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    logic       stall_prev = 1'b0;
    logic [9:0] stall_beat;

    // Scoreboard monitor plus payload-stability check during stalls.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(m_if.tvalid), 32'd1);
                chk("stall_payload", 32'({m_if.tdata, m_if.tuser, m_if.tlast}), 32'(stall_beat));
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'({m_if.tdata, m_if.tuser, m_if.tlast}), 32'h3ff);
                end else begin
                    chk("out_beat", 32'({m_if.tdata, m_if.tuser, m_if.tlast}), 32'(exp_q.pop_front()));
                end
            end
            stall_prev = m_if.tvalid & ~m_if.tready;
            stall_beat = {m_if.tdata, m_if.tuser, m_if.tlast};
        end
    end

    // Occupancy seen by the scoreboard must be at most 2 and gate source ready.
    always @(posedge clk) begin
        #2;
        if (occ_en && !rst) begin
            chk("occ_le2", 32'(exp_q.size() <= 2), 32'd1);
            chk("ready_vs_occ", 32'(s_if.tready), 32'(exp_q.size() < 2));
        end
    end

    task automatic send(input logic tu, input logic tl, input logic etu, input logic etl,
                        input logic clr);
        int  cyc = 0;
        logic ok = 1'b1;
        s_if.tdata  = dval;
        s_if.tuser  = tu;
        s_if.tlast  = tl;
        s_if.tvalid = 1'b1;
        err_clr     = clr;
        @(negedge clk);
        while (!s_if.tready) begin
            cyc++;
            if (cyc > 200) begin
                chk("input_accept_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (ok) exp_q.push_back({dval, etu, etl});
        dval = dval + 8'd1;
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic send_normal(input int x, input int y);
        logic tu = (x == 0) && (y == 0);
        logic tl = (x == 7);
        send(tu, tl, tu, tl, 1'b0);
    endtask

    task automatic send_line(input int y);
        for (int x = 0; x < 8; x++) send_normal(x, y);
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("cleared", 32'({err_early, err_late, err_sof}), 32'd0);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'd0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 32'd0);
        chk("rst_ready", 32'(s_if.tready), 32'd0);
        chk("rst_status", 32'({err_early, err_late, err_sof, frame_cnt}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(s_if.tready), 32'd1);

        // Two well-formed frames, ready held high.
        send_normal(0, 0);
        chk("latency_1", 32'(m_if.tvalid), 32'd1);
        for (int x = 1; x < 8; x++) send_normal(x, 0);
        for (int y = 1; y < 4; y++) send_line(y);
        for (int y = 0; y < 4; y++) send_line(y);
        drain();
        chk("frames_2", 32'(frame_cnt), 32'd2);
        chk("no_errs", 32'({err_early, err_late, err_sof}), 32'd0);

        // Early EOL at x=5 of line 1.
        send_line(0);
        for (int x = 0; x < 5; x++) send_normal(x, 1);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("early_eol_set", 32'(err_early), 32'd1);
        chk("early_only", 32'({err_late, err_sof}), 32'd0);
        send_line(2);
        send_line(3);
        drain();
        chk("frames_3", 32'(frame_cnt), 32'd3);
        clear_errs();

        // Missing source tlast at x=7 of line 0.
        for (int x = 0; x < 7; x++) send_normal(x, 0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("late_eol_set", 32'(err_late), 32'd1);
        for (int y = 1; y < 4; y++) send_line(y);
        drain();
        chk("frames_4", 32'(frame_cnt), 32'd4);
        chk("late_only", 32'({err_early, err_sof}), 32'd0);
        clear_errs();

        // Stray SOF at (3,2) together with err clear: set wins, frame restarts.
        send_line(0);
        send_line(1);
        for (int x = 0; x < 3; x++) send_normal(x, 2);
        send(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sof_set_over_clr", 32'(err_sof), 32'd1);
        chk("frames_after_sof", 32'(frame_cnt), 32'd4);
        for (int x = 1; x < 8; x++) send_normal(x, 0);
        send_line(1);
        send_line(2);
        for (int x = 0; x < 7; x++) send_normal(x, 3);
        chk("frames_before_end", 32'(frame_cnt), 32'd4);
        send_normal(7, 3);
        chk("frames_5", 32'(frame_cnt), 32'd5);
        drain();
        clear_errs();

        // Random downstream ready with continuous source valid.
        rand_mode = 1'b1;
        occ_en    = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int y = 0; y < 4; y++) send_line(y);
        occ_en    = 1'b0;
        rand_mode = 1'b0;
        drain();
        chk("frames_7", 32'(frame_cnt), 32'd7);
        chk("rand_no_errs", 32'({err_early, err_late, err_sof}), 32'd0);

        // Reset mid-line 2 with two beats buffered.
        send_line(0);
        send_line(1);
        for (int x = 0; x < 3; x++) send_normal(x, 2);
        drain();
        ready_fixed = 1'b0;
        @(posedge clk);
        #1;
        send_normal(3, 2);
        send_normal(4, 2);
        chk("ready_low_when_full", 32'(s_if.tready), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_outputs", 32'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 32'd0);
        chk("midrst_ready", 32'(s_if.tready), 32'd0);
        chk("midrst_status", 32'({err_early, err_late, err_sof, frame_cnt}), 32'd0);
        ready_fixed = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_midrst", 32'(s_if.tready), 32'd1);
        send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int x = 1; x < 8; x++) send_normal(x, 0);
        drain();
        chk("post_rst_frames", 32'(frame_cnt), 32'd0);
        chk("post_rst_errs", 32'({err_early, err_late, err_sof}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
